// File: rtl/fsm_datapath_slice_if.sv
// Controller-to-datapath control bundle plus the result bus and flags returned to the controller.
// The controller side uses the master modport and the datapath uses the slave modport.
interface fsm_datapath_slice_if;
    logic [15:0] immediate;
    logic        imm_control;
    logic [4:0]  control1;
    logic [4:0]  control2;
    logic [7:0]  opcode;
    logic        buff_en;
    logic [15:0] enable;
    logic [15:0] bus;
    logic [3:0]  flags;

    modport master (
        output immediate, imm_control, control1, control2, opcode, buff_en, enable,
        input  bus, flags
    );

    modport slave (
        input  immediate, imm_control, control1, control2, opcode, buff_en, enable,
        output bus, flags
    );
endinterface

// File: rtl/fsm_datapath_slice.sv
// Datapath slice: register file, operand latches A/B, ALU, result bus, {V,N,Z,C} flags, debug port, sticky protocol error.
// Optional macro DATAPATH_MUL_EN adds opcode 0x09 (low 16 bits of A*B).
module fsm_datapath_slice #(
    parameter int NUM_REGS = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    fsm_datapath_slice_if.slave         ctl,
    input  logic [3:0]                  dbg_sel,
    output logic [15:0]                 dbg_data,
    output logic                        proto_err
);

    localparam logic [4:0]  NUM_REGS_W = 5'(NUM_REGS);
    localparam logic [15:0] IMPL_MASK  = 16'((32'd1 << NUM_REGS) - 32'd1);

    logic [15:0] regs [16];
    logic [15:0] lat_a, lat_b;
    logic [3:0]  flags_q;
    logic        proto_err_q;

    logic [15:0] result;
    logic        c_out, v_out, op_valid;
    logic [16:0] sum17, diff17, shl17, shr17;
`ifdef DATAPATH_MUL_EN
    logic [31:0] prod;
`endif

    // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
    always_comb begin
        result   = '0;
        c_out    = 1'b0;
        v_out    = 1'b0;
        op_valid = 1'b1;
        sum17    = {1'b0, lat_a} + {1'b0, lat_b};
        diff17   = {1'b0, lat_a} - {1'b0, lat_b};
        shl17    = {1'b0, lat_a} << lat_b[3:0];
        // Bit 0 of the right shift catches the last bit shifted out.
        shr17    = {lat_a, 1'b0} >> lat_b[3:0];
`ifdef DATAPATH_MUL_EN
        prod     = lat_a * lat_b;
`endif
        case (ctl.opcode)
            8'h00: result = lat_a;
            8'h01: result = lat_a & lat_b;
            8'h02: result = lat_a | lat_b;
            8'h03: result = lat_a ^ lat_b;
            8'h04: result = ~lat_a;
            8'h05: begin
                result = sum17[15:0];
                c_out  = sum17[16];
                v_out  = (lat_a[15] == lat_b[15]) && (sum17[15] != lat_a[15]);
            end
            8'h06: begin
                result = diff17[15:0];
                c_out  = diff17[16];
                v_out  = (lat_a[15] != lat_b[15]) && (diff17[15] != lat_a[15]);
            end
            8'h07: begin
                result = shl17[15:0];
                c_out  = shl17[16];
            end
            8'h08: begin
                result = shr17[16:1];
                c_out  = shr17[0];
            end
`ifdef DATAPATH_MUL_EN
            8'h09: begin
                result = prod[15:0];
                c_out  = |prod[31:16];
            end
`endif
            default: op_valid = 1'b0;
        endcase
    end

    assign ctl.bus   = ctl.buff_en ? result : 16'h0000;
    assign ctl.flags = flags_q;
    assign proto_err = proto_err_q;
    assign dbg_data  = ({1'b0, dbg_sel} < NUM_REGS_W) ? regs[dbg_sel] : 16'h0000;

    logic        a_bad, b_bad, en_bad, op_bad, a_load, b_load;
    logic [15:0] wr_mask;

    always_comb begin
        a_bad   = ctl.control1 > NUM_REGS_W;
        a_load  = (ctl.control1 != 5'd0) && !a_bad;
        b_bad   = ctl.imm_control ? (ctl.control2 != 5'd0) : (ctl.control2 > NUM_REGS_W);
        b_load  = !ctl.imm_control && (ctl.control2 != 5'd0) && !b_bad;
        en_bad  = ((ctl.enable != 16'h0000) && !ctl.buff_en) || ((ctl.enable & ~IMPL_MASK) != 16'h0000);
        op_bad  = ctl.buff_en && !op_valid;
        wr_mask = ctl.buff_en ? (ctl.enable & IMPL_MASK) : 16'h0000;
    end

    // NOTE: non-blocking assignments throughout, so latch loads see the register values from before this edge's writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the register file is cleared on reset because the debug port must read zero immediately afterwards.
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
            lat_a       <= 16'h0000;
            lat_b       <= 16'h0000;
            flags_q     <= 4'h0;
            proto_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (wr_mask[i]) regs[i] <= ctl.bus;
            end
            if (a_load) lat_a <= regs[ctl.control1[3:0] - 4'd1];
            if (ctl.imm_control) lat_b <= ctl.immediate;
            else if (b_load) lat_b <= regs[ctl.control2[3:0] - 4'd1];
            if (ctl.buff_en && op_valid) flags_q <= {v_out, result[15], result == 16'h0000, c_out};
            if (a_bad || b_bad || en_bad || op_bad) proto_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fsm_datapath_slice.sv
// Directed self-checking bench for fsm_datapath_slice; expectations are hand-computed constants.
// Handles both builds of the DATAPATH_MUL_EN option.
module tb_fsm_datapath_slice;

    logic        clk;
    logic        reset;
    logic [3:0]  dbg_sel;
    logic [15:0] dbg_data;
    logic        proto_err;
    int          checks   = 0;
    int          failures = 0;

    fsm_datapath_slice_if dp ();

    fsm_datapath_slice #(.NUM_REGS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .ctl       (dp.slave),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic imm_c, input logic [15:0] immv, input logic [4:0] c1,
                         input logic [4:0] c2, input logic [7:0] op, input logic be,
                         input logic [15:0] en);
        dp.imm_control = imm_c;
        dp.immediate   = immv;
        dp.control1    = c1;
        dp.control2    = c2;
        dp.opcode      = op;
        dp.buff_en     = be;
        dp.enable      = en;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h00, 1'b0, 16'h0000);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reg(input string tag, input int idx, input logic [15:0] exp);
        dbg_sel = 4'(idx);
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp);
        check(tag, {12'h000, dp.flags}, {12'h000, exp});
    endtask

    task automatic check_err(input string tag, input logic exp);
        check(tag, {15'h0000, proto_err}, {15'h0000, exp});
    endtask

    int          fib_exp [6] = '{0, 1, 1, 2, 3, 5};
    logic [7:0]  alu_op  [6] = '{8'h07, 8'h08, 8'h06, 8'h01, 8'h03, 8'h04};
    logic [15:0] alu_bus [6] = '{16'h0002, 16'h4000, 16'h8000, 16'h0001, 16'h8000, 16'h7FFE};
    logic [3:0]  alu_flg [6] = '{4'b0001, 4'b0001, 4'b0100, 4'b0000, 4'b0100, 4'b0000};

    initial begin
        dbg_sel = 4'h0;
        reset   = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        for (int i = 0; i < 16; i++) check_reg($sformatf("rst_r%0d", i), i, 16'h0000);
        check_flags("rst_flags", 4'h0);
        check_err("rst_proto_err", 1'b0);
        check("rst_bus", dp.bus, 16'h0000);

        // Fibonacci: r1 = r0 + 1, then r(k) = r(k-1) + r(k-2)
        drive(1'b0, 16'h0000, 5'd1, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        drive(1'b1, 16'h0001, 5'd0, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h05, 1'b1, 16'h0002); #1;
        check("fib_bus1", dp.bus, 16'h0001);
        tick();
        check_reg("fib_r1", 1, 16'h0001);
        for (int k = 2; k <= 5; k++) begin
            drive(1'b0, 16'h0000, 5'(k), 5'(k - 1), 8'h00, 1'b0, 16'h0000); tick();
            drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h05, 1'b1, 16'(1 << k)); #1;
            check($sformatf("fib_bus%0d", k), dp.bus, 16'(fib_exp[k]));
            tick();
            check_reg($sformatf("fib_r%0d", k), k, 16'(fib_exp[k]));
        end
        check_flags("fib_flags", 4'b0000);

        // Wrap: 0xFFFF + 1 into r2
        drive(1'b1, 16'hFFFF, 5'd1, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h02, 1'b1, 16'h0040); tick();
        drive(1'b1, 16'h0001, 5'd7, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h05, 1'b1, 16'h0004); #1;
        check("wrap_bus", dp.bus, 16'h0000);
        tick();
        check_reg("wrap_r2", 2, 16'h0000);
        check_flags("wrap_flags", 4'b0011);

        // Signed overflow: 0x7FFF + 1
        drive(1'b1, 16'h7FFF, 5'd1, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h02, 1'b1, 16'h0080); tick();
        drive(1'b1, 16'h0001, 5'd8, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h05, 1'b1, 16'h0000); #1;
        check("ovf_bus", dp.bus, 16'h8000);
        tick();
        check_flags("ovf_flags", 4'b1100);

        // Read-before-write: write r3 <= 7 while A loads r3 (old value 2)
        drive(1'b1, 16'h0007, 5'd1, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        drive(1'b0, 16'h0000, 5'd4, 5'd0, 8'h02, 1'b1, 16'h0008); #1;
        check("rbw_bus", dp.bus, 16'h0007);
        tick();
        check_reg("rbw_r3", 3, 16'h0007);
        drive(1'b0, 16'h0000, 5'd4, 5'd0, 8'h00, 1'b1, 16'h0000); #1;
        check("rbw_old_a", dp.bus, 16'h0002);
        tick();
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h00, 1'b1, 16'h0000); #1;
        check("rbw_new_a", dp.bus, 16'h0007);
        check_err("rbw_no_err", 1'b0);

        // Enable without buff_en: no write, sticky error
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h00, 1'b0, 16'h0010); tick();
        check_reg("enb_r4_kept", 4, 16'h0003);
        check_err("enb_err", 1'b1);
        idle(); tick(); tick();
        check_err("enb_err_sticky", 1'b1);
        do_reset();
        check_err("enb_err_cleared", 1'b0);
        check_reg("rst_r4", 4, 16'h0000);

        // Out-of-range control1: A holds
        drive(1'b1, 16'h0005, 5'd0, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h02, 1'b1, 16'h0002); tick();
        drive(1'b0, 16'h0000, 5'd2, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        check_err("c1_ok_no_err", 1'b0);
        drive(1'b0, 16'h0000, 5'd20, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        check_err("c1_oor_err", 1'b1);
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h00, 1'b1, 16'h0000); #1;
        check("c1_oor_a_held", dp.bus, 16'h0005);

        // imm_control priority over control2
        do_reset();
        drive(1'b1, 16'h0009, 5'd0, 5'd2, 8'h00, 1'b0, 16'h0000); tick();
        check_err("prio_err", 1'b1);
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h02, 1'b1, 16'h0000); #1;
        check("prio_b_imm", dp.bus, 16'h0009);

        // Reset during a write cycle
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h02, 1'b1, 16'h0002);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check_reg("rstw_r1", 1, 16'h0000);
        check_err("rstw_err", 1'b0);
        check_flags("rstw_flags", 4'b0000);

        // Shifts, SUB, logic ops with A=0x8001, B=1
        drive(1'b1, 16'h8001, 5'd0, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h02, 1'b1, 16'h0002); tick();
        drive(1'b1, 16'h0001, 5'd2, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 16'h0000, 5'd0, 5'd0, alu_op[i], 1'b1, 16'h0000); #1;
            check($sformatf("alu_bus_op%0h", alu_op[i]), dp.bus, alu_bus[i]);
            tick();
            check_flags($sformatf("alu_flags_op%0h", alu_op[i]), alu_flg[i]);
        end
        drive(1'b1, 16'h8002, 5'd0, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h06, 1'b1, 16'h0000); #1;
        check("borrow_bus", dp.bus, 16'hFFFF);
        tick();
        check_flags("borrow_flags", 4'b0101);
        check_err("alu_no_err", 1'b0);

        // Opcode 0x09 with A=B=0x0100
        do_reset();
        drive(1'b1, 16'h0100, 5'd1, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h02, 1'b1, 16'h0002); tick();
        drive(1'b0, 16'h0000, 5'd2, 5'd0, 8'h00, 1'b0, 16'h0000); tick();
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'h09, 1'b1, 16'h0000); #1;
        check("mul_bus", dp.bus, 16'h0000);
        tick();
`ifdef DATAPATH_MUL_EN
        check_flags("mul_flags", 4'b0011);
        check_err("mul_err", 1'b0);
`else
        check_flags("mul_invalid_flags_hold", 4'b0000);
        check_err("mul_invalid_err", 1'b1);
`endif

        // Invalid opcode driven onto the bus
        do_reset();
        drive(1'b0, 16'h0000, 5'd0, 5'd0, 8'hFF, 1'b1, 16'h0000); #1;
        check("badop_bus", dp.bus, 16'h0000);
        tick();
        check_err("badop_err", 1'b1);
        check_flags("badop_flags_hold", 4'b0000);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
